logic_pipe: RTL

LOGIC_PIPE -- requirements
Module: logic_pipe

---
 rtl/logic_pipe.sv | 126 ++++++++++++
 1 files changed

// File: rtl/logic_pipe.sv
// Pipelined bitwise logic unit with valid/ready handshake and a delivered-result counter.
// Optional macro LOGIC_PIPE_PARITY_EN adds out_parity, pipelined alongside the result.
module logic_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [15:0]      out_count
`ifdef LOGIC_PIPE_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  function automatic logic [WIDTH-1:0] eval_op(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [1:0]       op);
    logic [WIDTH-1:0] r;
    case (op)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      2'b11:   r = ~(a & b);
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  function automatic logic parity_of(input logic [WIDTH-1:0] x);
    return ^x;
  endfunction

  logic                         advance_s;
  logic [WIDTH-1:0]             stage1_s;
  logic [DEPTH-1:0]             valid_q, valid_d, valid_shift_s;
  logic [DEPTH-1:0][WIDTH-1:0]  data_q, data_d, data_shift_s;
  logic [15:0]                  out_count_q, out_count_d;

  // Whole pipe moves as one unit; it only stalls when a result is waiting downstream.
  assign advance_s = !valid_q[DEPTH-1] || out_ready;
  assign in_ready  = advance_s;
  assign stage1_s  = eval_op(in_a, in_b, in_op);

  assign valid_shift_s[0] = in_valid;
  assign data_shift_s[0]  = stage1_s;
  for (genvar g = 1; g < DEPTH; g++) begin : g_shift
    assign valid_shift_s[g] = valid_q[g-1];
    assign data_shift_s[g]  = data_q[g-1];
  end

  // Next-state for the stage registers and the delivered-result counter.
  always_comb begin
    valid_d     = valid_q;
    data_d      = data_q;
    out_count_d = out_count_q;
    if (advance_s) begin
      valid_d = valid_shift_s;
      data_d  = data_shift_s;
    end else begin
      valid_d = valid_q;
      data_d  = data_q;
    end
    if (valid_q[DEPTH-1] && out_ready) begin
      out_count_d = out_count_q + 16'd1;
    end else begin
      out_count_d = out_count_q;
    end
  end

  // Stage and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= {DEPTH{1'b0}};
      data_q      <= '0;
      out_count_q <= 16'd0;
    end else begin
      valid_q     <= valid_d;
      data_q      <= data_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign out_count = out_count_q;

`ifdef LOGIC_PIPE_PARITY_EN
  logic [DEPTH-1:0] par_q, par_d, par_shift_s;

  assign par_shift_s[0] = parity_of(stage1_s);
  for (genvar g = 1; g < DEPTH; g++) begin : g_par_shift
    assign par_shift_s[g] = par_q[g-1];
  end

  // Parity follows its result through the same shift/hold decisions.
  always_comb begin
    par_d = par_q;
    if (advance_s) begin
      par_d = par_shift_s;
    end else begin
      par_d = par_q;
    end
  end

  // Parity stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= {DEPTH{1'b0}};
    end else begin
      par_q <= par_d;
    end
  end

  assign out_parity = par_q[DEPTH-1];
`endif

endmodule
